// File: rtl/fsm_trace_checker_if.sv
// Observation bus from the FSM harness into the trace checker.
// Handshake: valid-only. A tuple (obs_in, obs_cs, obs_ns, obs_out) is consumed
// on every rising clk edge where obs_valid is high. There is no ready and no
// backpressure, because the checker accepts a tuple on every cycle.
interface fsm_trace_checker_if #(
  parameter int OUT_W = 4
);
  logic             obs_valid;
  logic [1:0]       obs_in;
  logic [1:0]       obs_cs;
  logic [1:0]       obs_ns;
  logic [OUT_W-1:0] obs_out;

  modport master (output obs_valid, obs_in, obs_cs, obs_ns, obs_out);
  modport slave  (input  obs_valid, obs_in, obs_cs, obs_ns, obs_out);
endinterface

// File: rtl/fsm_trace_checker.sv
// Trace checker for a 3-state, 3-input Mealy FSM.
// In LEARN mode, the checker records observed transitions into a table indexed
// by cs*NUM_IN+in. In CHECK mode, it compares new tuples against that table.
// All flags are registered and appear one cycle after the tuple.
module fsm_trace_checker #(
  parameter int NUM_ST = 3,
  parameter int NUM_IN = 3,
  parameter int OUT_W  = 4,
  parameter int ERR_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     mode,
  input  logic                     stop,
  input  logic                     clear,
  fsm_trace_checker_if.slave       obs,
  input  logic [3:0]               rd_idx,
  output logic                     busy,
  output logic                     rd_valid,
  output logic [1:0]               rd_ns,
  output logic [OUT_W-1:0]         rd_out,
  output logic [NUM_ST*NUM_IN-1:0] covered,
  output logic [3:0]               cov_count,
  output logic                     full_cov,
  output logic                     mismatch,
  output logic                     unseen,
  output logic                     illegal,
  output logic                     chain_err,
  output logic [ERR_W-1:0]         err_count,
  output logic [3:0]               last_err_idx,
  output logic [1:0]               dbg_state
);
  localparam int NUM_ENT = NUM_ST * NUM_IN;
  localparam logic [1:0] MAX_ST = 2'(NUM_ST - 1);
  localparam logic [1:0] MAX_IN = 2'(NUM_IN - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LEARN = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  logic [1:0]         state, state_nx;
  logic [NUM_ENT-1:0] tbl_valid;
  logic [1:0]         tbl_ns  [NUM_ENT];
  logic [OUT_W-1:0]   tbl_out [NUM_ENT];
  logic               hist_valid;
  logic [1:0]         hist_ns;

  logic               take, bad_enc, legal, hit, differs;
  logic               is_illegal, is_chain, do_mismatch, do_unseen, do_write, do_clear;
  logic [3:0]         idx;
  logic [1:0]         err_inc;
  logic [ERR_W:0]     err_sum;

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;
  assign covered   = tbl_valid;
  assign full_cov  = (cov_count == 4'(NUM_ENT));

  // Next-state logic: start (only honoured in IDLE) wins over stop.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:            if (start) state_nx = mode ? ST_CHECK : ST_LEARN;
      ST_LEARN, ST_CHECK: if (stop)  state_nx = ST_IDLE;
      default:            state_nx = ST_IDLE;
    endcase
  end

  // Classify the incoming tuple; an illegal encoding short-circuits every other check.
  always_comb begin
    take        = busy && obs.obs_valid;
    bad_enc     = (obs.obs_in > MAX_IN) || (obs.obs_cs > MAX_ST) || (obs.obs_ns > MAX_ST);
    is_illegal  = take && bad_enc;
    legal       = take && !bad_enc;
    idx         = 4'(obs.obs_cs) * 4'(NUM_IN) + 4'(obs.obs_in);
    hit         = 1'b0;
    differs     = 1'b0;
    if (legal) begin
      hit     = tbl_valid[idx];
      differs = (tbl_ns[idx] != obs.obs_ns) || (tbl_out[idx] != obs.obs_out);
    end
    is_chain    = legal && hist_valid && (obs.obs_cs != hist_ns);
    do_mismatch = legal && hit && differs;
    do_write    = legal && !hit && (state == ST_LEARN);
    do_unseen   = legal && !hit && (state == ST_CHECK);
    do_clear    = (state == ST_IDLE) && clear;
    err_inc     = 2'(is_illegal) + 2'(is_chain) + 2'(do_mismatch);
    err_sum     = {1'b0, err_count} + (ERR_W+1)'(err_inc);
  end

  // Mode register and chain history; the history restarts on every session entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      hist_valid <= 1'b0;
      hist_ns    <= 2'd0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && start) begin
        hist_valid <= 1'b0;
      end else if (legal) begin
        hist_valid <= 1'b1;
        hist_ns    <= obs.obs_ns;
      end
    end
  end

  // Table valid bits and coverage count; the first recorded value per entry is kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      tbl_valid <= '0;
      cov_count <= 4'd0;
    end else if (do_clear) begin
      tbl_valid <= '0;
      cov_count <= 4'd0;
    end else if (do_write) begin
      tbl_valid[idx] <= 1'b1;
      cov_count      <= cov_count + 4'd1;
    end
  end

  // Table payload; this needs no reset because the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (do_write) begin
      tbl_ns[idx]  <= obs.obs_ns;
      tbl_out[idx] <= obs.obs_out;
    end
  end

  // Event pulses, saturating error counter and the last error index.
  always_ff @(posedge clk) begin
    if (reset) begin
      mismatch     <= 1'b0;
      unseen       <= 1'b0;
      illegal      <= 1'b0;
      chain_err    <= 1'b0;
      err_count    <= '0;
      last_err_idx <= 4'd0;
    end else begin
      mismatch  <= do_mismatch;
      unseen    <= do_unseen;
      illegal   <= is_illegal;
      chain_err <= is_chain;
      err_count <= err_sum[ERR_W] ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];
      if (do_mismatch || do_unseen) last_err_idx <= idx;
    end
  end

  // Registered readback that forwards a same-cycle write or clear; invalid entries read as zero.
  always_ff @(posedge clk) begin
    if (reset || do_clear || rd_idx >= 4'(NUM_ENT)) begin
      rd_valid <= 1'b0;
      rd_ns    <= 2'd0;
      rd_out   <= '0;
    end else if (do_write && idx == rd_idx) begin
      rd_valid <= 1'b1;
      rd_ns    <= obs.obs_ns;
      rd_out   <= obs.obs_out;
    end else if (tbl_valid[rd_idx]) begin
      rd_valid <= 1'b1;
      rd_ns    <= tbl_ns[rd_idx];
      rd_out   <= tbl_out[rd_idx];
    end else begin
      rd_valid <= 1'b0;
      rd_ns    <= 2'd0;
      rd_out   <= '0;
    end
  end
endmodule

// File: tb/tb_fsm_trace_checker.sv
// Bench for fsm_trace_checker: directed scenarios with literal expectations,
// a randomized phase, and a per-cycle comparison against a behavioural model.
`timescale 1ns/1ps
module tb_fsm_trace_checker;
  localparam int OUT_W = 4;
  localparam int ERR_W = 8;
  localparam int EW    = 38;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, mode = 1'b0, stop = 1'b0, clear = 1'b0;
  logic [3:0] rd_idx = 4'd0;
  logic busy, rd_valid, full_cov, mismatch, unseen, illegal, chain_err;
  logic [1:0] rd_ns, dbg_state;
  logic [OUT_W-1:0] rd_out;
  logic [8:0] covered;
  logic [3:0] cov_count, last_err_idx;
  logic [ERR_W-1:0] err_count;

  fsm_trace_checker_if #(.OUT_W(OUT_W)) obs_bus ();

  fsm_trace_checker #(.NUM_ST(3), .NUM_IN(3), .OUT_W(OUT_W), .ERR_W(ERR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .stop(stop), .clear(clear),
    .obs(obs_bus.slave), .rd_idx(rd_idx), .busy(busy), .rd_valid(rd_valid),
    .rd_ns(rd_ns), .rd_out(rd_out), .covered(covered), .cov_count(cov_count),
    .full_cov(full_cov), .mismatch(mismatch), .unseen(unseen), .illegal(illegal),
    .chain_err(chain_err), .err_count(err_count), .last_err_idx(last_err_idx),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_mode = 0;                 // 0 idle, 1 learn, 2 check
  bit m_valid [9];
  int m_ns [9];
  int m_out [9];
  bit h_valid = 0;
  int h_ns = 0;
  int m_err = 0;
  int m_last = 0;
  logic [EW-1:0] exp_q[$];

  // At each rising edge, apply the observed behaviour rules to the model and queue the expected outputs.
  always @(posedge clk) begin : model
    int errs, idx, cnt, rv, rn, ro;
    bit mm, un, il, ce;
    logic [8:0] cov;
    errs = 0; mm = 0; un = 0; il = 0; ce = 0; rv = 0; rn = 0; ro = 0;
    if (reset) begin
      m_mode = 0; h_valid = 0; m_err = 0; m_last = 0;
      for (int i = 0; i < 9; i++) m_valid[i] = 0;
    end else begin
      if (m_mode != 0 && obs_bus.obs_valid) begin
        if (obs_bus.obs_in == 3 || obs_bus.obs_cs == 3 || obs_bus.obs_ns == 3) begin
          il = 1; errs++;
        end else begin
          idx = int'(obs_bus.obs_cs) * 3 + int'(obs_bus.obs_in);
          if (h_valid && int'(obs_bus.obs_cs) != h_ns) begin ce = 1; errs++; end
          h_valid = 1; h_ns = int'(obs_bus.obs_ns);
          if (m_valid[idx]) begin
            if (m_ns[idx] != int'(obs_bus.obs_ns) || m_out[idx] != int'(obs_bus.obs_out)) begin
              mm = 1; errs++; m_last = idx;
            end
          end else if (m_mode == 1) begin
            m_valid[idx] = 1; m_ns[idx] = int'(obs_bus.obs_ns); m_out[idx] = int'(obs_bus.obs_out);
          end else begin
            un = 1; m_last = idx;
          end
        end
      end
      m_err = (m_err + errs > 255) ? 255 : m_err + errs;
      if (m_mode == 0 && clear)
        for (int i = 0; i < 9; i++) m_valid[i] = 0;
      if (m_mode == 0) begin
        if (start) begin m_mode = mode ? 2 : 1; h_valid = 0; end
      end else if (stop) begin
        m_mode = 0;
      end
      if (rd_idx < 9 && m_valid[rd_idx]) begin
        rv = 1; rn = m_ns[rd_idx]; ro = m_out[rd_idx];
      end
    end
    cnt = 0;
    for (int i = 0; i < 9; i++) begin
      cov[i] = m_valid[i];
      cnt += int'(m_valid[i]);
    end
    exp_q.push_back({(m_mode != 0), rv[0], rn[1:0], ro[3:0], cov, cnt[3:0], (cnt == 9),
                     mm, un, il, ce, m_err[7:0], m_last[3:0]});
  end

  // ---------------- scoreboard: compare every cycle on the falling edge ----------------
  always @(negedge clk) begin : compare
    logic [EW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("busy",         32'(busy),         32'(e[37]));
      chk("rd_valid",     32'(rd_valid),     32'(e[36]));
      chk("rd_ns",        32'(rd_ns),        32'(e[35:34]));
      chk("rd_out",       32'(rd_out),       32'(e[33:30]));
      chk("covered",      32'(covered),      32'(e[29:21]));
      chk("cov_count",    32'(cov_count),    32'(e[20:17]));
      chk("full_cov",     32'(full_cov),     32'(e[16]));
      chk("mismatch",     32'(mismatch),     32'(e[15]));
      chk("unseen",       32'(unseen),       32'(e[14]));
      chk("illegal",      32'(illegal),      32'(e[13]));
      chk("chain_err",    32'(chain_err),    32'(e[12]));
      chk("err_count",    32'(err_count),    32'(e[11:4]));
      chk("last_err_idx", 32'(last_err_idx), 32'(e[3:0]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_obs(input int in_v, input int cs_v, input int ns_v, input int out_v);
    obs_bus.obs_valid = 1'b1;
    obs_bus.obs_in = 2'(in_v); obs_bus.obs_cs = 2'(cs_v);
    obs_bus.obs_ns = 2'(ns_v); obs_bus.obs_out = 4'(out_v);
    tick();
    obs_bus.obs_valid = 1'b0;
  endtask

  task automatic do_start(input logic m);
    start = 1'b1; mode = m; tick(); start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int last_ns;
    obs_bus.obs_valid = 1'b0; obs_bus.obs_in = 2'd0; obs_bus.obs_cs = 2'd0;
    obs_bus.obs_ns = 2'd0; obs_bus.obs_out = 4'd0;
    tick(); tick();
    reset = 1'b0;
    chk("lit_reset_busy", 32'(busy), 0);
    chk("lit_reset_cov", 32'(cov_count), 0);
    chk("lit_reset_err", 32'(err_count), 0);

    // Learn all nine entries with a consistent state chain.
    do_start(1'b0);
    chk("lit_busy_learn", 32'(busy), 1);
    for (int k = 0; k < 9; k++)
      drive_obs(k % 3, k / 3, (k == 8) ? 0 : (k + 1) / 3, k);
    chk("lit_full_cnt", 32'(cov_count), 9);
    chk("lit_full_cov", 32'(full_cov), 1);
    chk("lit_full_map", 32'(covered), 32'h1FF);
    chk("lit_full_err", 32'(err_count), 0);

    // A clear while busy is ignored; a clear in IDLE empties the table.
    clear = 1'b1; tick(); clear = 1'b0;
    chk("lit_clear_busy", 32'(cov_count), 9);
    do_stop();
    clear = 1'b1; tick(); clear = 1'b0;
    chk("lit_clear_idle", 32'(cov_count), 0);
    chk("lit_clear_map", 32'(covered), 0);

    // LEARN conflict keeps the first value.
    do_start(1'b0);
    drive_obs(2, 1, 0, 5);
    drive_obs(2, 1, 2, 5);
    chk("lit_learn_mm", 32'(mismatch), 1);
    chk("lit_learn_idx", 32'(last_err_idx), 5);
    chk("lit_learn_chain", 32'(chain_err), 1);
    chk("lit_learn_err", 32'(err_count), 2);
    rd_idx = 4'd5; tick();
    chk("lit_mm_pulse", 32'(mismatch), 0);
    chk("lit_rd_valid", 32'(rd_valid), 1);
    chk("lit_rd_ns", 32'(rd_ns), 0);
    chk("lit_rd_out", 32'(rd_out), 5);
    drive_obs(1, 0, 2, 3);
    chk("lit_err3", 32'(err_count), 3);

    // CHECK: unseen entry, then a conflict on a learned entry.
    do_stop(); do_start(1'b1);
    drive_obs(0, 0, 0, 0);
    chk("lit_unseen", 32'(unseen), 1);
    chk("lit_unseen_err", 32'(err_count), 3);
    drive_obs(1, 0, 1, 3);
    chk("lit_check_mm", 32'(mismatch), 1);
    chk("lit_check_err", 32'(err_count), 4);

    // Illegal input leaves coverage and history alone; the next tuple breaks the chain.
    drive_obs(3, 1, 0, 0);
    chk("lit_illegal", 32'(illegal), 1);
    chk("lit_ill_map", 32'(covered), 32'h022);
    chk("lit_ill_err", 32'(err_count), 5);
    drive_obs(0, 2, 0, 0);
    chk("lit_chain", 32'(chain_err), 1);
    chk("lit_chain_err", 32'(err_count), 6);
    do_stop();

    // Randomized phase, checked cycle by cycle against the model.
    last_ns = 0;
    for (int c = 0; c < 1500; c++) begin
      reset = ($urandom_range(0, 399) == 0);
      start = ($urandom_range(0, 24) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      clear = ($urandom_range(0, 19) == 0);
      mode  = 1'($urandom_range(0, 1));
      rd_idx = 4'($urandom_range(0, 15));
      obs_bus.obs_valid = ($urandom_range(0, 9) < 7);
      obs_bus.obs_in  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      obs_bus.obs_cs  = ($urandom_range(0, 3) != 0) ? 2'(last_ns) : 2'($urandom_range(0, 3));
      obs_bus.obs_ns  = 2'($urandom_range(0, 2));
      obs_bus.obs_out = 4'($urandom_range(0, 1));
      last_ns = int'(obs_bus.obs_ns);
      tick();
    end
    reset = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; obs_bus.obs_valid = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;

    // Saturate the error counter, then reset in the middle of CHECK.
    do_start(1'b0);
    drive_obs(2, 1, 0, 5);
    do_stop(); do_start(1'b1);
    for (int k = 0; k < 300; k++) drive_obs(2, 1, 1, 5);
    chk("lit_sat", 32'(err_count), 255);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("lit_abort_busy", 32'(busy), 0);
    chk("lit_abort_err", 32'(err_count), 0);
    chk("lit_abort_map", 32'(covered), 0);

    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
